// File: rtl/dequant_pkg.sv
// Shared widths, FSM state type, lane payload and saturation helper for the
// int8 -> int32 dequantizer pipeline.
package dequant_pkg;

  localparam int unsigned LANES_DEF = 4;
  localparam int unsigned FRAC_DEF  = 24;

  localparam int unsigned LANE_W  = 8;
  localparam int unsigned DIFF_W  = 9;
  localparam int unsigned SCALE_W = 32;
  localparam int unsigned PROD_W  = 42;
  localparam int unsigned OUT_W   = 32;

  typedef enum logic {IDLE, ISSUE} state_t;

  // One lane handed from the word issuer to the arithmetic pipe
  typedef struct packed {
    logic [LANE_W-1:0]  x;
    logic [LANE_W-1:0]  zp;
    logic [SCALE_W-1:0] scale;
    logic               last;
  } lane_req_t;

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(64'sh0000_0000_7FFF_FFFF);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-64'sh0000_0000_8000_0000);

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [PROD_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
    else                  r = v[OUT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/dequant_lane_datapath.sv
// Three-stage lane pipe: zero-point subtract, scale multiply, round+saturate.
// All stages advance together on en; valid/last ride alongside the data.
module dequant_lane_datapath
  import dequant_pkg::*;
#(
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    req_valid,
  input  lane_req_t               req,
  output logic signed [OUT_W-1:0] out_value,
  output logic                    out_valid,
  output logic                    out_last
);

  localparam logic signed [PROD_W-1:0] HALF = PROD_W'(1) <<< (FRAC - 1);

  logic                      s1_valid;
  logic                      s1_last;
  logic signed [DIFF_W-1:0]  s1_diff;
  logic        [SCALE_W-1:0] s1_scale;
  logic                      s2_valid;
  logic                      s2_last;
  logic signed [PROD_W-1:0]  s2_prod;

  logic signed [DIFF_W-1:0]  diff_c;
  logic signed [PROD_W-1:0]  prod_c;
  logic signed [PROD_W-1:0]  round_c;

  assign diff_c  = $signed({req.x[LANE_W-1], req.x}) - $signed({req.zp[LANE_W-1], req.zp});
  // Scale is zero-extended so 0xFFFFFFFF stays a large positive factor
  assign prod_c  = PROD_W'(s1_diff) * $signed({{(PROD_W - SCALE_W){1'b0}}, s1_scale});
  assign round_c = (s2_prod + HALF) >>> FRAC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_diff   <= '0;
      s1_scale  <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_prod   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_value <= '0;
    end else if (en) begin
      s1_valid  <= req_valid;
      s1_last   <= req_valid && req.last;
      s1_diff   <= diff_c;
      s1_scale  <= req.scale;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_prod   <= prod_c;
      out_valid <= s2_valid;
      out_last  <= s2_last;
      out_value <= saturate(round_c);
    end
  end

endmodule

// File: rtl/dequantizer_pipeline.sv
// Word-to-lane issuer for the int8 dequantizer: latches a packed word with its
// scale/zero point and feeds one lane per cycle into the arithmetic pipe.
module dequantizer_pipeline
  import dequant_pkg::*;
#(
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned FRAC  = FRAC_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [LANE_W*LANES-1:0]   in_word,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SCALE_W-1:0]        scale,
  input  logic [LANE_W-1:0]         zero_point,
  output logic signed [OUT_W-1:0]   out_value,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  state_t                    state;
  state_t                    next_state;
  logic [IDX_W-1:0]          lane_idx;
  logic [IDX_W-1:0]          next_idx;
  logic [LANE_W*LANES-1:0]   word_q;
  logic [SCALE_W-1:0]        scale_q;
  logic [LANE_W-1:0]         zp_q;
  logic                      active;
  logic                      advance;
  logic                      issue;
  logic                      load;
  logic                      last_lane;
  logic [LANE_W-1:0]         lane_x;
  lane_req_t                 req;

  assign advance   = !(out_valid && !out_ready);
  assign last_lane = (lane_idx == LAST_IDX);

  always_comb begin
    lane_x = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_idx == IDX_W'(i)) lane_x = word_q[i*LANE_W +: LANE_W];
    end
  end

  assign req = '{x: lane_x, zp: zp_q, scale: scale_q, last: last_lane};

  // Next state, lane counter and handshake; in_ready waits one cycle after reset
  always_comb begin
    next_state = state;
    next_idx   = lane_idx;
    in_ready   = 1'b0;
    issue      = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = active && advance;
        if (in_valid && active && advance) begin
          load       = 1'b1;
          next_state = ISSUE;
          next_idx   = '0;
        end
      end
      ISSUE: begin
        if (advance) begin
          issue = 1'b1;
          if (last_lane) begin
            in_ready = 1'b1;
            next_idx = '0;
            if (in_valid) load = 1'b1;
            else          next_state = IDLE;
          end else begin
            next_idx = lane_idx + IDX_W'(1);
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      lane_idx <= '0;
      active   <= 1'b0;
      word_q   <= '0;
      scale_q  <= '0;
      zp_q     <= '0;
    end else begin
      active   <= 1'b1;
      state    <= next_state;
      lane_idx <= next_idx;
      if (load) begin
        word_q  <= in_word;
        scale_q <= scale;
        zp_q    <= zero_point;
      end
    end
  end

  dequant_lane_datapath #(.FRAC(FRAC)) u_datapath (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (advance),
    .req_valid (issue),
    .req       (req),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_dequantizer_pipeline.sv
// Directed bench for dequantizer_pipeline: table of words with hand-computed
// lane results plus latency, back-to-back, stall and mid-word reset sequences.
module tb_dequantizer_pipeline;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [31:0]        in_word;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        scale;
  logic [7:0]         zero_point;
  logic signed [31:0] out_value;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0]       word;
    logic [31:0]       scale;
    logic [7:0]        zp;
    logic [3:0][31:0]  exp;
  } vec_t;

  vec_t        vecs [5];
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;

  dequantizer_pipeline dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .scale      (scale),
    .zero_point (zero_point),
    .out_value  (out_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) required %0d (0x%08h)", name,
               $signed(act), act, $signed(req), req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] w, input logic [31:0] s, input logic [7:0] z,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.word  = w;
    v.scale = s;
    v.zp    = z;
    v.exp   = {e3, e2, e1, e0};
    return v;
  endfunction

  // Every accepted output beat is compared in order against the queue
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_value", out_value, mon_e[31:0]);
        check("out_last", 32'(out_last), 32'(mon_e[32]));
      end
    end
  end

  task automatic push(input int vi);
    for (int l = 0; l < 4; l++) exp_q.push_back({(l == 3), vecs[vi].exp[l]});
  endtask

  task automatic drive(input int vi);
    in_word    = vecs[vi].word;
    scale      = vecs[vi].scale;
    zero_point = vecs[vi].zp;
  endtask

  // Returns #1 after the accepting posedge with in_valid dropped
  task automatic send(input int vi, input bit do_push);
    int n;
    if (do_push) push(vi);
    @(negedge clk);
    drive(vi);
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int          n;
    int          stale;
    logic [7:0]  ir_bits;
    logic [11:0] ov_bits;
    logic        w1_pending;

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_word    = '0;
    scale      = '0;
    zero_point = '0;
    out_ready  = 1'b1;

    vecs[0] = mk(32'h807FFF01, 32'h01000000, 8'h00, 32'd1, 32'hFFFF_FFFF, 32'd127, 32'hFFFF_FF80);
    vecs[1] = mk(32'hFF01FD03, 32'h00800000, 8'h00, 32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0);
    vecs[2] = mk(32'hFF007F80, 32'h01000000, 8'h80, 32'd0, 32'd255, 32'd128, 32'd127);
    vecs[3] = mk(32'h7F7F7F7F, 32'hFFFFFFFF, 8'h80, 32'd65280, 32'd65280, 32'd65280, 32'd65280);
    vecs[4] = mk(32'h9C00141E, 32'h00C00000, 8'h0A, 32'd15, 32'd8, 32'hFFFF_FFF9, 32'hFFFF_FFAE);

    repeat (2) @(negedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_value", out_value, 32'd0);
    check("reset_out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table: one word at a time, outputs checked by the monitor
    for (int i = 0; i < 5; i++) begin
      send(i, 1'b1);
      if (i == 0) begin
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("first_out_latency", 32'(n), 32'd3);
      end
      drain();
    end

    // Back-to-back words with in_valid held
    push(0);
    push(1);
    @(negedge clk);
    drive(0);
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("b2b_accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    ir_bits    = '0;
    ov_bits    = '0;
    w1_pending = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) drive(1);
      #1;
      if (k <= 8) ir_bits[k-1] = in_ready;
      ov_bits[k-1] = out_valid;
      if (w1_pending && in_ready) begin
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        w1_pending = 1'b0;
      end
    end
    check("b2b_in_ready_pattern", 32'(ir_bits), 32'h88);
    check("b2b_out_valid_pattern", 32'(ov_bits), 32'h7F8);
    drain();

    // Stall for 5 cycles while lane 0 is presented and lane 3 is waiting to issue
    send(4, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_value", out_value, vecs[4].exp[0]);
      check("stall_out_last", 32'(out_last), 32'd0);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset pulse with lanes in flight
    send(0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_value", out_value, 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("release_in_ready_now", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("release_in_ready_next", 32'(in_ready), 32'd1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("stale_outputs", 32'(stale), 32'd0);
    send(2, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dequantizer_pipeline.md
Name: dequantizer_pipeline

Overview:
Reverse of the int32→int8 quantizer. Takes 32-bit memory words holding packed int8 activations and issues one lane per cycle. Each lane is dequantized as round((x − zero_point) × scale / 2^FRAC) and emitted as a signed int32 in the accumulator domain. It sits between the activation buffer read port and the accumulator/residual-add path, with valid/ready handshakes on both sides.

Parameters:
LANES, 4, int8 lanes per input word (word width = 8×LANES).
FRAC, 24, fractional bits of scale (Q8.24 by default).

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
in_word  input  8*LANES  packed int8 lanes; lane 0 = bits [7:0]
in_valid  input  1  in_word/scale/zero_point valid
in_ready  output  1  word accepted when in_valid && in_ready
scale  input  32  unsigned Q(32−FRAC).FRAC dequant scale, sampled with the word
zero_point  input  8  signed int8 zero point, sampled with the word
out_value  output  32  signed dequantized result
out_valid  output  1  out_value valid
out_ready  input  1  downstream accept
out_last  output  1  marks the last lane of a word

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_value=0, out_last=0. FSM=IDLE, lane_idx=0, all stage valids=0.
- Reset is asynchronous and clears everything. A partially issued word is dropped, with no partial output after release.
- Stall: stall = out_valid && !out_ready; advance = !stall. When stalled, every stage, the FSM and the output hold their values.
- FSM:
  - IDLE: in_ready=advance. On accept, latch word, scale and zero_point, then go to ISSUE with lane_idx=0.
  - ISSUE: on each advance, issue lane lane_idx to stage 1. lane_idx increments, wrapping at LANES−1.
  - On the advance that issues lane LANES−1, in_ready=1. If in_valid is also high, the next word is latched and ISSUE continues at lane 0 with no bubble. Otherwise go to IDLE.
  - No ready→valid combinational path from out_ready to in_ready beyond the advance term.
- Stage 1 (sub): d = sext(x) − sext(zero_point), 9-bit signed, range [−255,255]. Carries a last flag.
- Stage 2 (mul): p = d × $signed({1'b0,scale}), 42-bit signed. Scale is never treated as negative.
- Stage 3 (round): r = (p + 2^(FRAC−1)) >>> FRAC, arithmetic shift, round-half-up. This matches the quantizer's rounding.
- Output: saturate r to [−2^31, 2^31−1] into out_value. out_valid follows stage-3 valid. out_last = last flag.
- Latency: a lane issued on cycle N appears on out_value at cycle N+3 with no stalls. Throughput is 1 lane/cycle.
- Simultaneous events:
  - Accepting a new word on the same edge as the last lane issues is legal.
  - A stall asserted on that same edge blocks both the issue and the accept.
- scale and zero_point changes take effect only at word boundaries.

Decomposition:
- Package dequant_pkg:
  - LANES and FRAC defaults.
  - Widths: LANE_W=8, DIFF_W=9, PROD_W=42, OUT_W=32.
  - State enum {IDLE, ISSUE}.
  - Saturation bounds constants.
- Sub-module dequant_lane_datapath: the 3-stage sub/mul/round/saturate pipe, with an enable (advance) and valid/last sideband.
- Top module: FSM, word latch and lane mux.

Test Plan:
- scale=0x01000000 (1.0), zp=0, word 0x807FFF01 → out 1, −1, 127, −128 in order; out_last only on −128; first out_valid 3 cycles after the accept edge.
- scale=0x00800000 (0.5), zp=0, lanes {3, −3, 1, −1} → out 2, −1, 1, 0 (round-half-up).
- scale=0x01000000, zp=−128, lanes {−128, 127, 0, −1} → out 0, 255, 128, 127. scale=0xFFFFFFFF, lane 127, zp=−128 → out 65280 (no negative scale).
- Two words back-to-back with in_valid held and out_ready=1 → 8 consecutive out_valid cycles, no bubble, in_ready high exactly on the last-lane issue cycles.
- out_ready low for 5 cycles mid-word → out_value/out_last stable, in_ready=0, no lane lost or duplicated. Resume yields the remaining lanes in order.
- reset_n pulsed low during lane 2 of a word → outputs zero immediately. After release: no stale outputs, in_ready=1 next cycle, and the next word is processed correctly.
